hilo_md_ctrl: RTL

//  Sequencer for the EX-stage multiply/divide units: accepts MULT/MULTU/DIV/DIVU from EX,

---
 rtl/hilo_md_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hilo_md_ctrl.sv
// Multiply/divide sequencer for the EX stage: issues one op to the mul or div core,
// stalls EX until the result is captured, then presents a single HI/LO write.
module hilo_md_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        pipe_stall,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall_req,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     a_reg, a_next;
  logic [31:0]     b_reg, b_next;
  logic            signed_reg, signed_next;
  logic [31:0]     hi_reg, hi_next;
  logic [31:0]     lo_reg, lo_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic one_hot;
  logic accept;
  logic is_mul;
  logic op_signed;

  // op_code is {mult, multu, div, divu}
  assign one_hot   = (op_code != 4'd0) && ((op_code & (op_code - 4'd1)) == 4'd0);
  assign accept    = (state_reg == IDLE) && op_valid && one_hot && !flush;
  assign is_mul    = op_code[3] | op_code[2];
  assign op_signed = op_code[3] | op_code[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      signed_reg <= signed_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    signed_next = signed_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    cnt_next    = cnt_reg;
    stall_req   = 1'b0;
    mul_signed  = 1'b0;
    mul_a       = '0;
    mul_b       = '0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_a       = '0;
    div_b       = '0;
    div_annul   = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hi_out      = '0;
    lo_out      = '0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          stall_req   = 1'b1;
          a_next      = src_a;
          b_next      = src_b;
          signed_next = op_signed;
          cnt_next    = '0;
          if (is_mul) begin
            state_next = MUL_WAIT;
          end else if (src_b == 32'd0) begin
            // Divide by zero never reaches the core; result is fixed.
            state_next = DONE;
            hi_next    = src_a;
            lo_next    = 32'hFFFF_FFFF;
          end else begin
            state_next = DIV_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        stall_req  = 1'b1;
        mul_signed = signed_reg;
        mul_a      = a_reg;
        mul_b      = b_reg;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CW'(MUL_LAT)) begin
          hi_next    = mul_result[63:32];
          lo_next    = mul_result[31:0];
          state_next = DONE;
        end
      end
      DIV_WAIT: begin
        stall_req  = 1'b1;
        div_signed = signed_reg;
        div_a      = a_reg;
        div_b      = b_reg;
        if (div_ready) begin
          hi_next    = div_result[63:32];
          lo_next    = div_result[31:0];
          state_next = DONE;
        end else begin
          div_start = 1'b1;
        end
      end
      DONE: begin
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        hi_out = hi_reg;
        lo_out = lo_reg;
        if (!pipe_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A flush kills the op outright; only the div core needs to be told.
    if (flush) begin
      state_next = IDLE;
      stall_req  = 1'b0;
      hi_we      = 1'b0;
      lo_we      = 1'b0;
      hi_out     = '0;
      lo_out     = '0;
      div_start  = 1'b0;
      div_annul  = (state_reg == DIV_WAIT);
    end
  end

endmodule
